cp0_reg: RTL and testbench

Coprocessor-0 register file: the write-side endpoint for the CP0 write channel (write enable, 5-bit address, 32-bit data) that the memory stage forwards toward writeback. It holds Count, Compare, Status, Cause, EPC, PRId and Config. It runs the free-running Count timer and raises the timer interrupt. It also captures exception state (EPC, Cause.BD, Cause.ExcCode, Status.EXL) and clears it on ERET. It sits beside the register file and the HI/LO unit and is written in the writeback cycle.

---
 rtl/cp0_reg.sv | 142 ++++++++++++++
 tb/tb_cp0_reg.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_reg.sv
// cp0_reg: Coprocessor-0 register file written in the writeback cycle.
// Holds Count, Compare, Status, Cause, EPC and the constant PRId/Config
// values. It runs the free-running Count timer, raises a sticky timer
// interrupt, records exception state and clears EXL on ERET.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-low reset
//   we_i/waddr_i/data_i mtc0 write channel
//   raddr_i/data_o      mfc0 combinational read port
//   int_i               external interrupt levels, sampled into Cause[15:10]
//   exc_i, exc_code_i, exc_pc_i, in_delay_slot_i  exception commit
//   eret_i              ERET commit (clears Status.EXL)
//   count_o .. epc_o    current register values
//   timer_int_o         registered timer interrupt pending
module cp0_reg #(
  parameter logic [31:0] PRID       = 32'h0001_8000,
  parameter logic [31:0] CONFIG_RST = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic        exc_i,
  input  logic [4:0]  exc_code_i,
  input  logic [31:0] exc_pc_i,
  input  logic        in_delay_slot_i,
  input  logic        eret_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        timer_int_o
);

  localparam logic [4:0] AddrCount   = 5'd9;
  localparam logic [4:0] AddrCompare = 5'd11;
  localparam logic [4:0] AddrStatus  = 5'd12;
  localparam logic [4:0] AddrCause   = 5'd13;
  localparam logic [4:0] AddrEpc     = 5'd14;
  localparam logic [4:0] AddrPrid    = 5'd15;
  localparam logic [4:0] AddrConfig  = 5'd16;

  localparam logic [31:0] StatusRst  = 32'h1000_0000;
  // Software-writable Cause bits: IV, WP, IP1..IP0.
  localparam logic [31:0] CauseWmask = 32'h00C0_0300;

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        timer_q, timer_d;

  logic wr_count, wr_compare;

  assign wr_count   = we_i && (waddr_i == AddrCount);
  assign wr_compare = we_i && (waddr_i == AddrCompare);

  always_comb begin
    count_d   = wr_count ? data_i : count_q + 32'd1;
    compare_d = wr_compare ? data_i : compare_q;

    // Sticky match; a Compare write acknowledges it and beats a same-cycle match.
    timer_d = timer_q;
    if (wr_compare) begin
      timer_d = 1'b0;
    end else if ((compare_q != 32'd0) && (count_q == compare_q)) begin
      timer_d = 1'b1;
    end

    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;

    // exc beats eret beats mtc0 for Status/Cause/EPC.
    if (exc_i) begin
      if (!status_q[1]) begin
        epc_d       = in_delay_slot_i ? (exc_pc_i - 32'd4) : exc_pc_i;
        cause_d[31] = in_delay_slot_i;
        status_d[1] = 1'b1;
      end
      cause_d[6:2] = exc_code_i;
    end else if (eret_i) begin
      status_d[1] = 1'b0;
    end else if (we_i) begin
      case (waddr_i)
        AddrStatus: status_d = data_i;
        AddrCause:  cause_d  = (cause_q & ~CauseWmask) | (data_i & CauseWmask);
        AddrEpc:    epc_d    = data_i;
        default:    ;
      endcase
    end

    // Pending hardware interrupts are tracked every cycle regardless of writes.
    cause_d[15:10] = int_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      status_q  <= StatusRst;
      cause_q   <= 32'd0;
      epc_q     <= 32'd0;
      timer_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      status_q  <= status_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      timer_q   <= timer_d;
    end
  end

  always_comb begin
    data_o = 32'd0;
    case (raddr_i)
      AddrCount:   data_o = count_q;
      AddrCompare: data_o = compare_q;
      AddrStatus:  data_o = status_q;
      AddrCause:   data_o = cause_q;
      AddrEpc:     data_o = epc_q;
      AddrPrid:    data_o = PRID;
      AddrConfig:  data_o = CONFIG_RST;
      default:     data_o = 32'd0;
    endcase
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign timer_int_o = timer_q;

endmodule

// File: tb/tb_cp0_reg.sv
// Self-checking bench for cp0_reg: directed reset/wrap/timer sequences, a
// vector table for Cause/exception/priority cases, then randomized traffic
// checked against a register-level reference model.
module tb_cp0_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [5:0]  int_i;
  logic        exc_i;
  logic [4:0]  exc_code_i;
  logic [31:0] exc_pc_i;
  logic        in_delay_slot_i;
  logic        eret_i;
  logic [31:0] data_o;
  logic [31:0] count_o, compare_o, status_o, cause_o, epc_o;
  logic        timer_int_o;

  int n_tests = 0;
  int n_fail  = 0;

  cp0_reg dut (
    .clk             (clk),
    .rst             (rst),
    .we_i            (we_i),
    .waddr_i         (waddr_i),
    .data_i          (data_i),
    .raddr_i         (raddr_i),
    .int_i           (int_i),
    .exc_i           (exc_i),
    .exc_code_i      (exc_code_i),
    .exc_pc_i        (exc_pc_i),
    .in_delay_slot_i (in_delay_slot_i),
    .eret_i          (eret_i),
    .data_o          (data_o),
    .count_o         (count_o),
    .compare_o       (compare_o),
    .status_o        (status_o),
    .cause_o         (cause_o),
    .epc_o           (epc_o),
    .timer_int_o     (timer_int_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] data;
    logic [5:0]  intr;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        slot;
    logic        eret;
    logic [4:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[17];

  // Reference model state.
  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
  logic        m_timer;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we_i = 1'b0; waddr_i = 5'd0; data_i = 32'd0;
    exc_i = 1'b0; exc_code_i = 5'd0; exc_pc_i = 32'd0;
    in_delay_slot_i = 1'b0; eret_i = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; data_i = d;
    step();
    we_i = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd9:  return m_count;
      5'd11: return m_compare;
      5'd12: return m_status;
      5'd13: return m_cause;
      5'd14: return m_epc;
      5'd15: return 32'h0001_8000;
      5'd16: return 32'h0000_8000;
      default: return 32'd0;
    endcase
  endfunction

  // One clock of architectural behaviour, applied to the model state.
  task automatic model_clock();
    logic [31:0] n_count, n_compare, n_status, n_cause, n_epc;
    logic        n_timer;
    n_count   = m_count + 32'd1;
    n_compare = m_compare;
    n_timer   = m_timer;
    if (m_compare != 0 && m_count == m_compare) n_timer = 1'b1;
    if (we_i && waddr_i == 5'd9) n_count = data_i;
    if (we_i && waddr_i == 5'd11) begin
      n_compare = data_i;
      n_timer   = 1'b0;
    end
    n_status = m_status;
    n_cause  = m_cause;
    n_epc    = m_epc;
    if (exc_i) begin
      if (m_status[1] == 1'b0) begin
        n_epc       = in_delay_slot_i ? exc_pc_i - 32'd4 : exc_pc_i;
        n_cause[31] = in_delay_slot_i;
        n_status[1] = 1'b1;
      end
      n_cause[6:2] = exc_code_i;
    end else if (eret_i) begin
      n_status[1] = 1'b0;
    end else if (we_i && waddr_i == 5'd12) begin
      n_status = data_i;
    end else if (we_i && waddr_i == 5'd13) begin
      n_cause[9:8]   = data_i[9:8];
      n_cause[23:22] = data_i[23:22];
    end else if (we_i && waddr_i == 5'd14) begin
      n_epc = data_i;
    end
    n_cause[15:10] = int_i;
    m_count = n_count; m_compare = n_compare; m_timer = n_timer;
    m_status = n_status; m_cause = n_cause; m_epc = n_epc;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'd13, 32'hFFFF_FFFF, 6'd1, 1'b0, 5'h00, 32'h0,    1'b0, 1'b0, 5'd13, 32'h00C0_0700};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,         6'd1, 1'b1, 5'h0C, 32'h1000, 1'b1, 1'b0, 5'd14, 32'h0000_0FFC};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,         6'd1, 1'b0, 5'h00, 32'h0,    1'b0, 1'b0, 5'd13, 32'h80C0_0730};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,         6'd1, 1'b0, 5'h00, 32'h0,    1'b0, 1'b0, 5'd12, 32'h1000_0002};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,         6'd1, 1'b1, 5'h08, 32'h2000, 1'b0, 1'b0, 5'd14, 32'h0000_0FFC};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,         6'd1, 1'b0, 5'h00, 32'h0,    1'b0, 1'b0, 5'd13, 32'h80C0_0720};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,         6'd1, 1'b0, 5'h00, 32'h0,    1'b0, 1'b1, 5'd12, 32'h1000_0000};
    vecs[7]  = '{1'b1, 5'd14, 32'hDEAD_BEEF, 6'd1, 1'b1, 5'h00, 32'h100,  1'b0, 1'b0, 5'd14, 32'h0000_0100};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,         6'd1, 1'b0, 5'h00, 32'h0,    1'b0, 1'b0, 5'd13, 32'h00C0_0700};
    vecs[9]  = '{1'b1, 5'd9,  32'h5,         6'd1, 1'b0, 5'h00, 32'h0,    1'b0, 1'b0, 5'd9,  32'h0000_0005};
    vecs[10] = '{1'b1, 5'd15, 32'h0,         6'd1, 1'b0, 5'h00, 32'h0,    1'b0, 1'b0, 5'd15, 32'h0001_8000};
    vecs[11] = '{1'b0, 5'd0,  32'h0,         6'd1, 1'b0, 5'h00, 32'h0,    1'b0, 1'b0, 5'd16, 32'h0000_8000};
    vecs[12] = '{1'b0, 5'd0,  32'h0,         6'd1, 1'b0, 5'h00, 32'h0,    1'b0, 1'b0, 5'd3,  32'h0};
    vecs[13] = '{1'b1, 5'd12, 32'h0,         6'd1, 1'b0, 5'h00, 32'h0,    1'b0, 1'b1, 5'd12, 32'h1000_0000};
    vecs[14] = '{1'b0, 5'd0,  32'h0,         6'd1, 1'b1, 5'h01, 32'h0,    1'b1, 1'b0, 5'd14, 32'hFFFF_FFFC};
    vecs[15] = '{1'b1, 5'd12, 32'hABCD_0001, 6'd1, 1'b0, 5'h00, 32'h0,    1'b0, 1'b0, 5'd12, 32'hABCD_0001};
    vecs[16] = '{1'b1, 5'd13, 32'h0,      6'b100000, 1'b0, 5'h00, 32'h0,  1'b0, 1'b0, 5'd13, 32'h8000_8004};

    idle_inputs();
    int_i = 6'd0; raddr_i = 5'd15; rst = 1'b0;

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    check("rst_count", count_o, 32'd0);
    check("rst_compare", compare_o, 32'd0);
    check("rst_status", status_o, 32'h1000_0000);
    check("rst_cause", cause_o, 32'd0);
    check("rst_epc", epc_o, 32'd0);
    check("rst_timer", {31'd0, timer_int_o}, 32'd0);
    check("rst_prid", data_o, 32'h0001_8000);
    step();
    check("count_inc", count_o, 32'd1);

    // Count wrap.
    mtc0(5'd9, 32'hFFFF_FFFE);
    check("wrap0", count_o, 32'hFFFF_FFFE);
    step(); check("wrap1", count_o, 32'hFFFF_FFFF);
    step(); check("wrap2", count_o, 32'd0);

    // Timer match and stickiness.
    mtc0(5'd11, 32'h20);
    mtc0(5'd9, 32'h1E);
    check("tmr_pre", {31'd0, timer_int_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("tmr_count", count_o, 32'h1F + i);
      check("tmr_int", {31'd0, timer_int_o}, (i >= 2) ? 32'd1 : 32'd0);
    end
    mtc0(5'd11, 32'h40);
    check("tmr_clear", {31'd0, timer_int_o}, 32'd0);

    // Compare write coinciding with a match: the clear wins.
    mtc0(5'd9, 32'h3F);
    step();
    check("coin_count", count_o, 32'h40);
    mtc0(5'd11, 32'h40);
    check("coin_int", {31'd0, timer_int_o}, 32'd0);

    // Reset asserted during an exception discards it.
    exc_i = 1'b1; exc_pc_i = 32'h1234; rst = 1'b0;
    step();
    idle_inputs(); rst = 1'b1;
    check("rst_exc_epc", epc_o, 32'd0);
    check("rst_exc_status", status_o, 32'h1000_0000);

    // Vector table.
    for (int i = 0; i < 17; i++) begin
      we_i = vecs[i].we; waddr_i = vecs[i].waddr; data_i = vecs[i].data;
      int_i = vecs[i].intr; exc_i = vecs[i].exc; exc_code_i = vecs[i].code;
      exc_pc_i = vecs[i].pc; in_delay_slot_i = vecs[i].slot; eret_i = vecs[i].eret;
      step();
      idle_inputs();
      raddr_i = vecs[i].raddr;
      #1;
      check($sformatf("vec%0d", i), data_o, vecs[i].exp);
    end

    // Randomized traffic against the model, from a fresh reset.
    idle_inputs(); int_i = 6'd0; rst = 1'b0;
    step();
    rst = 1'b1;
    m_count = 0; m_compare = 0; m_status = 32'h1000_0000;
    m_cause = 0; m_epc = 0; m_timer = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] addrs[8];
      addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};
      we_i = ($urandom_range(0, 2) == 0);
      waddr_i = addrs[$urandom_range(0, 7)];
      if (waddr_i == 5'd11)
        data_i = ($urandom_range(0, 1) == 0) ? m_count + 32'($urandom_range(0, 6)) : $urandom;
      else if (waddr_i == 5'd9)
        data_i = ($urandom_range(0, 1) == 0) ? m_compare - 32'($urandom_range(0, 3)) : $urandom;
      else
        data_i = $urandom;
      raddr_i = addrs[$urandom_range(0, 7)];
      int_i = 6'($urandom);
      exc_i = ($urandom_range(0, 15) == 0);
      exc_code_i = 5'($urandom);
      exc_pc_i = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      in_delay_slot_i = 1'($urandom);
      eret_i = ($urandom_range(0, 9) == 0);
      model_clock();
      step();
      check("rnd_count", count_o, m_count);
      check("rnd_compare", compare_o, m_compare);
      check("rnd_status", status_o, m_status);
      check("rnd_cause", cause_o, m_cause);
      check("rnd_epc", epc_o, m_epc);
      check("rnd_timer", {31'd0, timer_int_o}, {31'd0, m_timer});
      check("rnd_rdata", data_o, model_read(raddr_i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
